// File: rtl/ddr_wr_arbiter.sv
// ddr_wr_arbiter
//
// Round-robin arbiter that shares one DDR write engine (mbus write channel)
// between NUM_CH frame writers. One eligible writer (wrq & wready) is granted
// per burst. Its address, data and handshakes are routed to the engine. After
// the burst ends, the channel stays idle for GUARD_CYCLES cycles so the writer's
// two-flop wbusy synchronizer can see the burst finish before re-arbitration.
//
// Ports
//   i_axi_aclk       clock for all logic
//   i_rst            synchronous, active-high reset
//   i_ch_wrq         per-channel write request
//   i_ch_wready      per-channel data ready
//   i_ch_waddr       packed per-channel addresses, channel 0 in the LSBs
//   i_ch_wdata       packed per-channel write data, channel 0 in the LSBs
//   o_ch_wsel        one-hot grant to the writers (REQ/BUSY)
//   o_ch_wdata_rq    engine data request, routed to the granted writer only
//   o_ch_wbusy       engine busy, routed to the granted writer only
//   o_mbus_wrq       write request to the engine (REQ only)
//   o_mbus_waddr     address of the granted writer (0 in IDLE)
//   o_mbus_wdata     data of the granted writer (0 in IDLE)
//   o_mbus_wready    ready of the granted writer (REQ/BUSY)
//   i_mbus_wdata_rq  engine data request
//   i_mbus_wbusy     engine busy
//   o_grant_id       index of the current or last grant
//   o_timeout        one-cycle pulse when a request is aborted by timeout

module ddr_wr_arbiter #(
  parameter int unsigned NUM_CH          = 4,
  parameter int unsigned CTRL_ADDR_WIDTH = 28,
  parameter int unsigned DATA_WIDTH      = 128,
  parameter int unsigned GUARD_CYCLES    = 3,
  parameter int unsigned TIMEOUT         = 1023
) (
  input  logic                              i_axi_aclk,
  input  logic                              i_rst,
  input  logic [NUM_CH-1:0]                 i_ch_wrq,
  input  logic [NUM_CH-1:0]                 i_ch_wready,
  input  logic [NUM_CH*CTRL_ADDR_WIDTH-1:0] i_ch_waddr,
  input  logic [NUM_CH*DATA_WIDTH-1:0]      i_ch_wdata,
  output logic [NUM_CH-1:0]                 o_ch_wsel,
  output logic [NUM_CH-1:0]                 o_ch_wdata_rq,
  output logic [NUM_CH-1:0]                 o_ch_wbusy,
  output logic                              o_mbus_wrq,
  output logic [CTRL_ADDR_WIDTH-1:0]        o_mbus_waddr,
  output logic [DATA_WIDTH-1:0]             o_mbus_wdata,
  output logic                              o_mbus_wready,
  input  logic                              i_mbus_wdata_rq,
  input  logic                              i_mbus_wbusy,
  output logic [$clog2(NUM_CH)-1:0]         o_grant_id,
  output logic                              o_timeout
);

  localparam int unsigned GW = $clog2(NUM_CH);

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StBusy,
    StGuard
  } state_e;

  state_e          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   last_q, last_d;
  logic [15:0]     tcnt_q;
  logic [3:0]      gcnt_q;

  logic [NUM_CH-1:0] elig;
  logic              any_elig;
  logic [GW-1:0]     pick;
  logic [GW-1:0]     cand;
  logic              tcnt_hit;
  logic              guard_done;
  logic              route_en;
  logic              sel_en;

  assign elig       = i_ch_wrq & i_ch_wready;
  // tcnt_q holds the number of REQ cycles already elapsed, so the hit fires
  // in the TIMEOUT-th REQ cycle.
  assign tcnt_hit   = (state_q == StReq) && (tcnt_q == 16'(TIMEOUT - 1));
  assign guard_done = (gcnt_q == 4'(GUARD_CYCLES - 1));
  assign o_grant_id = grant_q;

  // Round-robin search starting just after the last grant.
  always_comb begin
    any_elig = 1'b0;
    pick     = '0;
    cand     = '0;
    for (int unsigned k = 1; k <= NUM_CH; k++) begin
      cand = GW'((32'(last_q) + k) % NUM_CH);
      if (!any_elig && elig[cand]) begin
        any_elig = 1'b1;
        pick     = cand;
      end
    end
  end

  // State register
  always_ff @(posedge i_axi_aclk) begin
    if (i_rst) begin
      state_q <= StIdle;
      grant_q <= '0;
      last_q  <= GW'(NUM_CH - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  // Timeout and guard counters clear whenever their state is not active, so
  // they start from zero on every state entry.
  always_ff @(posedge i_axi_aclk) begin
    if (i_rst) begin
      tcnt_q <= '0;
      gcnt_q <= '0;
    end else begin
      tcnt_q <= (state_q == StReq) ? tcnt_q + 16'd1 : 16'd0;
      gcnt_q <= (state_q == StGuard) ? gcnt_q + 4'd1 : 4'd0;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    unique case (state_q)
      StIdle: begin
        if (any_elig) begin
          grant_d = pick;
          last_d  = pick;
          state_d = StReq;
        end
      end
      StReq: begin
        // Busy wins over a same-cycle timeout: the burst has started.
        if (i_mbus_wbusy) begin
          state_d = StBusy;
        end else if (tcnt_hit) begin
          state_d = StGuard;
        end
      end
      StBusy: begin
        if (!i_mbus_wbusy) begin
          state_d = StGuard;
        end
      end
      StGuard: begin
        if (guard_done) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output logic, decoded from the registered state and grant.
  always_comb begin
    route_en      = (state_q != StIdle);
    sel_en        = (state_q == StReq) || (state_q == StBusy);
    o_ch_wsel     = '0;
    o_ch_wdata_rq = '0;
    o_ch_wbusy    = '0;
    o_mbus_wrq    = (state_q == StReq);
    o_mbus_waddr  = '0;
    o_mbus_wdata  = '0;
    o_mbus_wready = 1'b0;
    o_timeout     = tcnt_hit && !i_mbus_wbusy;
    if (sel_en) begin
      o_ch_wsel[grant_q] = 1'b1;
      o_mbus_wready      = i_ch_wready[grant_q];
    end
    if (route_en) begin
      o_mbus_waddr           = i_ch_waddr[grant_q*CTRL_ADDR_WIDTH +: CTRL_ADDR_WIDTH];
      o_mbus_wdata           = i_ch_wdata[grant_q*DATA_WIDTH +: DATA_WIDTH];
      o_ch_wdata_rq[grant_q] = i_mbus_wdata_rq;
      o_ch_wbusy[grant_q]    = i_mbus_wbusy;
    end
  end

endmodule
